alu_issue_stage: RTL

//  Pipeline register between decode and the combinational ALU. Captures one decoded instruction,

---
 rtl/alu_issue_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Purpose : decode-to-ALU pipeline register with ALU_Select generation, operand select and result forwarding.
// Latency : 1 cycle from an accepted instruction to out_valid.
// Backpressure: in_ready = ~out_valid | out_ready; a held instruction stays frozen while out_ready is low.
//
// Ports: clk/rst_n (async active-low), flush; decode side in_valid/in_ready plus opcode, funct3,
// funct7_5, rs1/rs2/rd addresses, rs1/rs2 data and imm; alu_result feeds back the result of the
// held instruction; ALU side out_valid/out_ready, data1, data2, ALU_Select, rd_out, is_branch,
// illegal; issue_count counts completed downstream transfers and wraps.
module alu_issue_stage #(
    parameter int n     = 63,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    input  logic [4:0]       rd_addr,
    input  logic [n:0]       rs1_data,
    input  logic [n:0]       rs2_data,
    input  logic [n:0]       imm,
    input  logic [n:0]       alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [n:0]       data1,
    output logic [n:0]       data2,
    output logic [3:0]       ALU_Select,
    output logic [4:0]       rd_out,
    output logic             is_branch,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state_q, state_d;

    logic       depart;
    logic       accept;
    logic       fwd_en;
    logic [3:0] dec_sel;
    logic       dec_src2;   // 1: operand 2 comes from rs2, 0: from imm
    logic       dec_br;
    logic       dec_ill;
    logic [n:0] op1_nxt;
    logic [n:0] op2_nxt;

    assign in_ready = (state_q == EMPTY) | out_ready;
    assign depart   = (state_q == FULL) & out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Next state: flush wins, then a new accept, then a plain departure
    always_comb begin
        state_d = state_q;
        if (flush)       state_d = EMPTY;
        else if (accept) state_d = FULL;
        else if (depart) state_d = EMPTY;
    end

    // Output decode of the state
    always_comb begin
        out_valid = (state_q == FULL);
    end

    // Instruction decode into ALU operation and operand-2 source
    always_comb begin
        dec_sel  = 4'b0010;
        dec_src2 = 1'b0;
        dec_br   = 1'b0;
        dec_ill  = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_src2 = 1'b1;
                case (funct3)
                    3'b000:  dec_sel = funct7_5 ? 4'b0110 : 4'b0010;
                    3'b111:  dec_sel = 4'b0000;
                    3'b110:  dec_sel = 4'b0001;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                case (funct3)
                    3'b000:  dec_sel = 4'b0010;
                    3'b111:  dec_sel = 4'b0000;
                    3'b110:  dec_sel = 4'b0001;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0000011, 7'b0100011: dec_sel = 4'b0010;
            7'b1100011: begin
                dec_sel  = 4'b0110;
                dec_src2 = 1'b1;
                dec_br   = 1'b1;
            end
            7'b0110111: dec_sel = 4'b0111;
            default:    dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_sel  = 4'b0010;
            dec_src2 = 1'b0;
            dec_br   = 1'b0;
        end
    end

    // Only the instruction leaving this very cycle is forwarded; its result is on alu_result now.
    assign fwd_en = depart & (rd_out != 5'd0) & ~illegal;

    always_comb begin
        op1_nxt = '0;
        op2_nxt = '0;
        if (!dec_ill) begin
            op1_nxt = (fwd_en && (rs1_addr == rd_out)) ? alu_result : rs1_data;
            if (!dec_src2)                           op2_nxt = imm;
            else if (fwd_en && (rs2_addr == rd_out)) op2_nxt = alu_result;
            else                                     op2_nxt = rs2_data;
        end
    end

    // Held instruction; contents only change when a new instruction is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data1      <= '0;
            data2      <= '0;
            ALU_Select <= 4'b0000;
            rd_out     <= 5'd0;
            is_branch  <= 1'b0;
            illegal    <= 1'b0;
        end else if (accept) begin
            data1      <= op1_nxt;
            data2      <= op2_nxt;
            ALU_Select <= dec_sel;
            rd_out     <= rd_addr;
            is_branch  <= dec_br;
            illegal    <= dec_ill;
        end
    end

    // Departures count even when a flush lands in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      issue_count <= '0;
        else if (depart) issue_count <= issue_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule
